// File: rtl/bad_apple_pkg.sv
// bad_apple_pkg: shared state type, default geometry and derived index widths
package bad_apple_pkg;
  localparam int DEF_SEG_BITS = 48;
  localparam int DEF_NUM_SEGS = 15;
  localparam int DEF_TIMEOUT_CYCLES = 800000;
  localparam int SEG_IDX_W = $clog2(DEF_NUM_SEGS);
  localparam int BIT_IDX_W = $clog2(DEF_SEG_BITS);
  typedef enum logic [2:0] {IDLE, STARTUP, ARMED, FILL, WAIT_SWAP} state_t;
endpackage

// File: rtl/bank_fill_counter.sv
// bank_fill_counter: segment/bit write position within a bank with clear, increment and last-bit flag
module bank_fill_counter import bad_apple_pkg::*; #(
  parameter int SEG_BITS = DEF_SEG_BITS,
  parameter int NUM_SEGS = DEF_NUM_SEGS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  output logic [SEG_IDX_W-1:0] seg,
  output logic [BIT_IDX_W-1:0] idx,
  output logic                 last
);
  logic bit_wrap;
  always_comb begin
    bit_wrap = idx == BIT_IDX_W'(SEG_BITS - 1);
    last = bit_wrap && seg == SEG_IDX_W'(NUM_SEGS - 1);
  end
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      seg <= '0;
      idx <= '0;
    end else if (inc) begin
      idx <= bit_wrap ? '0 : idx + 1'b1;
      seg <= last ? '0 : bit_wrap ? seg + 1'b1 : seg;
    end
  end
endmodule

// File: rtl/frame_bank_scheduler.sv
// frame_bank_scheduler: ping-pong video bank sequencing between SPI payload fill and VGA readout
module frame_bank_scheduler import bad_apple_pkg::*; #(
  parameter int SEG_BITS = DEF_SEG_BITS,
  parameter int NUM_SEGS = DEF_NUM_SEGS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 CLK_40,
  input  logic                 reset,
  input  logic                 init,
  input  logic                 bit_valid,
  input  logic                 bit_data,
  input  logic                 frame_end,
  output logic                 chip_select,
  output logic                 wr_en,
  output logic                 wr_bank,
  output logic [SEG_IDX_W-1:0] wr_seg,
  output logic [BIT_IDX_W-1:0] wr_bit,
  output logic                 wr_data,
  output logic                 read_bank1,
  output logic                 read_bank2,
  output logic                 switch_mode,
  output logic                 startup_done,
  output logic                 underrun,
  output logic                 timeout_err
);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  state_t state, state_next;
  logic init_q, filling, take, swap, timeout, cs_pulse, last;
  logic [SEG_IDX_W-1:0] seg;
  logic [BIT_IDX_W-1:0] idx;
  logic [TO_W-1:0] idle_cnt;

  bank_fill_counter #(.SEG_BITS(SEG_BITS), .NUM_SEGS(NUM_SEGS)) u_cnt (
    .clk  (CLK_40),
    .rst  (reset),
    .clr  (swap || timeout),
    .inc  (take),
    .seg  (seg),
    .idx  (idx),
    .last (last)
  );

  always_comb begin
    filling = state == STARTUP || state == FILL;
    take = filling && bit_valid;
    swap = frame_end && (state == ARMED || state == WAIT_SWAP);
    timeout = filling && !bit_valid && idle_cnt == TO_W'(TIMEOUT_CYCLES - 1);
    chip_select = !filling || cs_pulse;
    state_next = state;
    case (state)
      IDLE:      state_next = init && !init_q ? STARTUP : IDLE;
      STARTUP:   state_next = take && last ? ARMED : STARTUP;
      ARMED:     state_next = frame_end ? FILL : ARMED;
      FILL:      state_next = take && last ? WAIT_SWAP : FILL;
      WAIT_SWAP: state_next = frame_end ? FILL : WAIT_SWAP;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK_40) begin
    if (reset) state <= IDLE;
    else state <= state_next;
  end

  always_ff @(posedge CLK_40) begin
    if (reset) begin
      init_q <= 1'b0;
      idle_cnt <= '0;
      cs_pulse <= 1'b0;
      wr_en <= 1'b0;
      wr_data <= 1'b0;
      wr_seg <= '0;
      wr_bit <= '0;
      wr_bank <= 1'b0;
      read_bank1 <= 1'b0;
      read_bank2 <= 1'b0;
      switch_mode <= 1'b0;
      startup_done <= 1'b0;
      underrun <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      init_q <= init;
      idle_cnt <= (!filling || bit_valid || timeout) ? '0 : idle_cnt + 1'b1;
      cs_pulse <= timeout;
      wr_en <= take;
      wr_data <= bit_data;
      if (take) begin
        wr_seg <= seg;
        wr_bit <= idx;
      end
      switch_mode <= swap;
      underrun <= frame_end && state == FILL;
      if (swap) begin
        read_bank1 <= !read_bank1;
        read_bank2 <= startup_done && !read_bank2;
        wr_bank <= !wr_bank;
        startup_done <= 1'b1;
      end
      if (timeout) timeout_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_frame_bank_scheduler.sv
// tb_frame_bank_scheduler: directed self-checking bench for the ping-pong bank scheduler
module tb_frame_bank_scheduler;
  import bad_apple_pkg::*;
  logic CLK_40 = 1'b0;
  logic reset = 1'b1;
  logic init = 1'b0;
  logic bit_valid = 1'b0;
  logic bit_data = 1'b0;
  logic frame_end = 1'b0;
  logic chip_select, wr_en, wr_bank, wr_data, read_bank1, read_bank2;
  logic switch_mode, startup_done, underrun, timeout_err;
  logic [SEG_IDX_W-1:0] wr_seg;
  logic [BIT_IDX_W-1:0] wr_bit;
  int n_cmp = 0;
  int n_bad = 0;

  frame_bank_scheduler #(.TIMEOUT_CYCLES(100)) dut (
    .CLK_40       (CLK_40),
    .reset        (reset),
    .init         (init),
    .bit_valid    (bit_valid),
    .bit_data     (bit_data),
    .frame_end    (frame_end),
    .chip_select  (chip_select),
    .wr_en        (wr_en),
    .wr_bank      (wr_bank),
    .wr_seg       (wr_seg),
    .wr_bit       (wr_bit),
    .wr_data      (wr_data),
    .read_bank1   (read_bank1),
    .read_bank2   (read_bank2),
    .switch_mode  (switch_mode),
    .startup_done (startup_done),
    .underrun     (underrun),
    .timeout_err  (timeout_err)
  );

  always #5 CLK_40 = ~CLK_40;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK_40);
    #1;
  endtask

  function automatic logic pat(input int i);
    return i[0] ^ i[2];
  endfunction

  task automatic send(input int i);
    bit_valid = 1'b1;
    bit_data = pat(i);
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic check_pos(input string tag, input int i);
    chk({tag, "_en"}, 32'(wr_en), 1);
    chk({tag, "_seg"}, 32'(wr_seg), i / 48);
    chk({tag, "_bit"}, 32'(wr_bit), i % 48);
    chk({tag, "_data"}, 32'(wr_data), 32'(pat(i)));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cs"}, 32'(chip_select), 1);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_wr_bank"}, 32'(wr_bank), 0);
    chk({tag, "_wr_seg"}, 32'(wr_seg), 0);
    chk({tag, "_wr_bit"}, 32'(wr_bit), 0);
    chk({tag, "_wr_data"}, 32'(wr_data), 0);
    chk({tag, "_rb1"}, 32'(read_bank1), 0);
    chk({tag, "_rb2"}, 32'(read_bank2), 0);
    chk({tag, "_switch"}, 32'(switch_mode), 0);
    chk({tag, "_startup"}, 32'(startup_done), 0);
    chk({tag, "_underrun"}, 32'(underrun), 0);
    chk({tag, "_timeout"}, 32'(timeout_err), 0);
  endtask

  initial begin
    tick();
    tick();
    check_reset("rst");
    reset = 1'b0;
    tick();
    chk("idle_cs", 32'(chip_select), 1);
    init = 1'b1;
    tick();
    init = 1'b0;
    chk("startup_cs", 32'(chip_select), 0);
    for (int i = 0; i < 100; i++) begin
      send(i);
      if (i == 0 || i == 47 || i == 48) check_pos("su_pos", i);
    end
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    chk("su_fe_underrun", 32'(underrun), 0);
    chk("su_fe_switch", 32'(switch_mode), 0);
    chk("su_fe_cs", 32'(chip_select), 0);
    for (int i = 100; i < 720; i++) send(i);
    check_pos("su_last", 719);
    chk("armed_state", 32'(dut.state), 32'(ARMED));
    chk("armed_cs", 32'(chip_select), 1);
    chk("armed_startup", 32'(startup_done), 0);
    send(5);
    chk("armed_drop", 32'(wr_en), 0);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    chk("sw1_rb1", 32'(read_bank1), 1);
    chk("sw1_rb2", 32'(read_bank2), 0);
    chk("sw1_wr_bank", 32'(wr_bank), 1);
    chk("sw1_switch", 32'(switch_mode), 1);
    chk("sw1_cs", 32'(chip_select), 0);
    chk("sw1_startup", 32'(startup_done), 1);
    tick();
    chk("sw1_switch_drop", 32'(switch_mode), 0);
    for (int i = 0; i < 300; i++) send(i);
    check_pos("fill300", 299);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    chk("ur_pulse", 32'(underrun), 1);
    chk("ur_rb1", 32'(read_bank1), 1);
    chk("ur_rb2", 32'(read_bank2), 0);
    chk("ur_switch", 32'(switch_mode), 0);
    tick();
    chk("ur_drop", 32'(underrun), 0);
    for (int i = 300; i < 720; i++) send(i);
    check_pos("fill_last", 719);
    chk("wait_cs", 32'(chip_select), 1);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    chk("sw2_rb1", 32'(read_bank1), 0);
    chk("sw2_rb2", 32'(read_bank2), 1);
    chk("sw2_wr_bank", 32'(wr_bank), 0);
    chk("sw2_switch", 32'(switch_mode), 1);
    for (int i = 0; i < 719; i++) send(i);
    frame_end = 1'b1;
    send(719);
    frame_end = 1'b0;
    check_pos("coinc_pos", 719);
    chk("coinc_underrun", 32'(underrun), 1);
    chk("coinc_switch", 32'(switch_mode), 0);
    chk("coinc_rb2", 32'(read_bank2), 1);
    chk("coinc_cs", 32'(chip_select), 1);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    chk("sw3_switch", 32'(switch_mode), 1);
    chk("sw3_rb1", 32'(read_bank1), 1);
    chk("sw3_rb2", 32'(read_bank2), 0);
    chk("sw3_wr_bank", 32'(wr_bank), 1);
    for (int i = 0; i < 5; i++) send(i);
    check_pos("pre_to", 4);
    for (int i = 0; i < 99; i++) tick();
    chk("to_before_cs", 32'(chip_select), 0);
    chk("to_before_err", 32'(timeout_err), 0);
    tick();
    chk("to_cs_high", 32'(chip_select), 1);
    chk("to_err", 32'(timeout_err), 1);
    tick();
    chk("to_cs_low", 32'(chip_select), 0);
    send(0);
    check_pos("to_restart", 0);
    for (int i = 1; i < 720; i++) send(i);
    chk("to_wait_cs", 32'(chip_select), 1);
    chk("to_err_sticky", 32'(timeout_err), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset("mid_rst");
    tick();
    tick();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    chk("post_rst_cs", 32'(chip_select), 1);
    chk("post_rst_switch", 32'(switch_mode), 0);
    init = 1'b1;
    tick();
    init = 1'b0;
    chk("restart_cs", 32'(chip_select), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/frame_bank_scheduler.md
Name: frame_bank_scheduler

Overview:
- Sequences the double-buffered (ping-pong) video memory between the SPI payload writer and the VGA reader.
- Requests payloads from the PC with chip_select and generates the bit-level write address into the fill bank.
- Swaps read and write banks only on a VGA frame boundary once the fill bank is complete.
- Handles startup, underrun (frame ends before the fill completes) and stalled-payload timeout.

Parameters:
- SEG_BITS, 48: bits per memory segment (MEMn depth).
- NUM_SEGS, 15: segments per bank (MEM1..MEM15).
- TIMEOUT_CYCLES, 800000: CLK_40 cycles with no bit_valid before a fill is aborted (20 ms).

Ports:
- CLK_40  in  1  system clock, 40 MHz.
- reset  in  1  synchronous, active-high.
- init  in  1  level; a rising edge while IDLE starts operation.
- bit_valid  in  1  one-cycle pulse per payload bit from the header-synchronised SPI deserialiser.
- bit_data  in  1  payload bit, qualified by bit_valid.
- frame_end  in  1  one-cycle pulse at the end of each VGA frame.
- chip_select  out  1  active-low payload request to the PC.
- wr_en  out  1  write strobe to the fill bank.
- wr_bank  out  1  0 = bank1, 1 = bank2.
- wr_seg  out  4  segment index, 0..NUM_SEGS-1.
- wr_bit  out  6  bit index within the segment, 0..SEG_BITS-1.
- wr_data  out  1  registered copy of bit_data.
- read_bank1  out  1  VGA reads bank1.
- read_bank2  out  1  VGA reads bank2.
- switch_mode  out  1  one-cycle pulse on each bank swap.
- startup_done  out  1  sticky; set on the first swap.
- underrun  out  1  one-cycle pulse when frame_end arrives before the fill bank is full.
- timeout_err  out  1  sticky; set when a fill is aborted by timeout.

Behaviour:
- Reset values: chip_select = 1; wr_en, wr_bank, wr_seg, wr_bit and wr_data = 0; read_bank1, read_bank2, switch_mode, startup_done, underrun and timeout_err = 0; state IDLE; all counters 0.
- A reset asserted mid-operation returns everything to these values on the next edge. Bank contents are not cleared.
- States:
  - IDLE: waits for an init rising edge. init is ignored in every other state.
  - STARTUP: fills bank1. chip_select = 0.
  - ARMED: bank1 full. chip_select = 1; waits for frame_end.
  - FILL: fills the bank that is not being read. chip_select = 0.
  - WAIT_SWAP: fill bank full. chip_select = 1; waits for frame_end.
- Transitions:
  - IDLE -> STARTUP on the init edge.
  - STARTUP -> ARMED on the last bit.
  - ARMED -> FILL on frame_end.
  - FILL -> WAIT_SWAP on the last bit.
  - WAIT_SWAP -> FILL on frame_end.
- Write path, in STARTUP and FILL only: bit_valid at cycle N gives wr_en = 1 at N+1, with wr_data = bit_data and wr_seg/wr_bit equal to the counter value before the increment.
  - wr_bit wraps SEG_BITS-1 -> 0 and increments wr_seg at the wrap.
  - The last bit is at (NUM_SEGS-1, SEG_BITS-1).
  - bit_valid is dropped in every other state.
- Swap (frame_end in ARMED or WAIT_SWAP), taking effect at the next edge:
  - read_bank1 and read_bank2 toggle. The first swap sets read_bank1 = 1, read_bank2 = 0.
  - wr_bank flips; the first swap sets wr_bank = 1.
  - Counters clear; switch_mode pulses; chip_select falls.
  - startup_done sets on the first swap.
- Simultaneous last bit and frame_end: the bank is not yet full, so no swap. The frame_end counts as an underrun and the swap waits for the next frame_end.
- frame_end in FILL: underrun pulses and the read bank is unchanged (the frame repeats).
- frame_end in IDLE or STARTUP: ignored.
- Timeout: the idle counter runs in STARTUP/FILL, clears on bit_valid and at state entry.
  - At TIMEOUT_CYCLES-1 the fill counters clear, chip_select goes high for exactly one cycle and then low again (re-request), and timeout_err sets.
  - The state does not change.

Decomposition:
- Shared package (bad_apple_pkg) holds:
  - the state enum;
  - SEG_BITS, NUM_SEGS and TIMEOUT_CYCLES defaults;
  - the derived widths SEG_IDX_W = $clog2(NUM_SEGS) and BIT_IDX_W = $clog2(SEG_BITS).
- One sub-module, bank_fill_counter: the seg/bit counter with clear, inc and last-bit flag.

Test Plan:
- Reset, init pulse, 720 bit_valid pulses -> chip_select low after init. At the 720th bit: wr_seg = 14, wr_bit = 47, state ARMED, chip_select = 1. startup_done still 0.
- ARMED then frame_end -> next cycle: read_bank1 = 1, wr_bank = 1, switch_mode high one cycle, chip_select = 0, startup_done = 1.
- FILL with 300 bits, then frame_end -> underrun pulses, read banks unchanged. The remaining 420 bits then frame_end -> read_bank2 = 1, read_bank1 = 0.
- Bit 720 and frame_end in the same cycle -> no swap and underrun pulses. The next frame_end swaps.
- In FILL, stall bit_valid for TIMEOUT_CYCLES (override to 100) -> chip_select high one cycle, counters 0, timeout_err = 1. The next bit writes to seg 0, bit 0.
- Reset asserted in WAIT_SWAP -> next cycle all outputs at reset values. init is required to restart.
